mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL be parameterless; widths: word address 30 b, word data 32 b, mem op 2 b (NOP=00, LDW=01, STW=10), ctrl op 2 b, reg address 5 b, exception code 3 b (NO_EXP=0, MISS_ALIGN=4).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 stall, flush  in  1 each  pipeline control; flush has priority over stall.
REQ-006 busy  out  1  bus access in progress, stall request to pipeline control.
REQ-007 fwd_data  out  32  combinational MEM result for forwarding.
REQ-008 ex_pc 30, ex_en 1, ex_br_flag 1, ex_mem_op 2, ex_mem_wr_data 32, ex_ctrl_op 2, ex_dst_addr 5, ex_gpr_we_ 1 (active-low), ex_exp_code 3, ex_out 32  in  EX/MEM register contents.
REQ-009 bus_req_ out 1, bus_grnt_ in 1, bus_as_ out 1, bus_rw out 1 (1=read, 0=write), bus_addr out 30, bus_wr_data out 32, bus_rd_data in 32, bus_rdy_ in 1; all strobes active-low.
REQ-010 mem_pc 30, mem_en 1, mem_br_flag 1, mem_ctrl_op 2, mem_dst_addr 5, mem_gpr_we_ 1, mem_exp_code 3, mem_out 32  out  MEM/WB register.

Function
REQ-011 Access address SHALL be ex_out[31:2]; miss_align SHALL be ex_en & (LDW|STW) & (ex_out[1:0]!=0).
REQ-012 A misaligned op SHALL start no bus access; result = ex_out.
REQ-013 Result SHALL be bus read data (or buffered data, REQ-020) for completed LDW, else ex_out; fwd_data = result.
REQ-014 Bus FSM states: IDLE, REQ, ACCESS, WAIT; reset state IDLE.
REQ-015 IDLE: on ex_en & aligned LDW/STW & !flush -> assert bus_req_, busy=1, go REQ; otherwise stay, bus idle.
REQ-016 REQ: keep bus_req_ low, busy=1; on bus_grnt_=0 drive bus_as_=0 for one cycle with bus_addr, bus_rw, bus_wr_data=ex_mem_wr_data, go ACCESS.
REQ-017 ACCESS: keep bus_req_ low, busy=1 until bus_rdy_=0; in that cycle busy=0, capture bus_rd_data into read buffer, release bus_req_, go WAIT if stall else IDLE.
REQ-018 WAIT: busy=0, result from read buffer; go IDLE when stall=0; no new request issued in WAIT.
REQ-019 Bus outputs SHALL idle at bus_req_=1, bus_as_=1, bus_rw=1, bus_addr=0, bus_wr_data=0 whenever not driven per REQ-016.
REQ-020 Read buffer SHALL hold last captured data until next capture; reset 0.
REQ-021 flush in any FSM state SHALL return to IDLE next cycle, release bus_req_/bus_as_, busy=0 that cycle.
REQ-022 Pipeline register update priority: flush > stall > load.
REQ-023 flush: mem_en=0, mem_ctrl_op=NOP, mem_gpr_we_=1, mem_exp_code=NO_EXP, all other mem_* =0.
REQ-024 stall (including stall caused by busy): all mem_* hold.
REQ-025 load: copy ex_* fields, mem_out=result; if miss_align then mem_exp_code=MISS_ALIGN, mem_gpr_we_=1, mem_ctrl_op=NOP, mem_en=ex_en.
REQ-026 STW SHALL never write mem_out from bus data; ex_gpr_we_ passes through unchanged for non-misaligned ops.

Reset
REQ-027 reset low SHALL immediately force FSM IDLE, busy=0, bus outputs per REQ-019, read buffer 0, and all mem_* to REQ-023 values, including mid-access.
REQ-028 First active edge after reset release SHALL behave as IDLE with empty pipeline.

Verification
REQ-029 ALU-only op, ex_out=0x1234_5678, ex_mem_op=NOP -> no bus_req_, next cycle mem_out=0x1234_5678, mem_en=1.
REQ-030 LDW ex_out=0x0000_0100, grant after 2 cycles, rdy after 3 -> bus_addr=0x40, bus_rw=1, bus_as_ low one cycle, busy high until rdy cycle, mem_out=bus_rd_data (0xDEAD_BEEF).
REQ-031 STW ex_out=0x0000_0010, wr_data=0xA5A5_A5A5 -> bus_rw=0, bus_addr=0x4, bus_wr_data=0xA5A5_A5A5, mem_out=0x0000_0010.
REQ-032 LDW ex_out=0x0000_0102 -> no bus_req_, mem_exp_code=4, mem_gpr_we_=1, busy=0.
REQ-033 LDW completing with stall=1 held 2 more cycles -> FSM WAIT, fwd_data=buffered data, no second bus_req_, mem_* load on stall release.
REQ-034 reset asserted in ACCESS, then flush asserted in REQ on a later access -> both: bus_req_=1, busy=0, FSM IDLE, mem_en=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// Memory bus between the MEM pipeline stage (master) and the bus arbiter/memory (slave).
// Every strobe is active-low. bus_rw is 1 for a read and 0 for a write.
interface mem_stage_if;
    logic        bus_req_;
    logic        bus_grnt_;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;

    modport master (
        output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
        input  bus_grnt_, bus_rd_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
        output bus_grnt_, bus_rd_data, bus_rdy_
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues word loads/stores on the shared bus and holds the MEM/WB register.
// busy stalls the pipeline while an access is outstanding, and fwd_data is the stage result.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] fwd_data,
    input  logic [29:0] ex_pc,
    input  logic        ex_en,
    input  logic        ex_br_flag,
    input  logic [1:0]  ex_mem_op,
    input  logic [31:0] ex_mem_wr_data,
    input  logic [1:0]  ex_ctrl_op,
    input  logic [4:0]  ex_dst_addr,
    input  logic        ex_gpr_we_,
    input  logic [2:0]  ex_exp_code,
    input  logic [31:0] ex_out,
    mem_stage_if.master bus,
    output logic [29:0] mem_pc,
    output logic        mem_en,
    output logic        mem_br_flag,
    output logic [1:0]  mem_ctrl_op,
    output logic [4:0]  mem_dst_addr,
    output logic        mem_gpr_we_,
    output logic [2:0]  mem_exp_code,
    output logic [31:0] mem_out
);
    localparam logic [1:0] MEM_OP_LDW     = 2'b01;
    localparam logic [1:0] MEM_OP_STW     = 2'b10;
    localparam logic [1:0] CTRL_OP_NOP    = 2'b00;
    localparam logic [2:0] EXP_NO         = 3'd0;
    localparam logic [2:0] EXP_MISS_ALIGN = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } state_e;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br_flag;
        logic [1:0]  ctrl_op;
        logic [4:0]  dst_addr;
        logic        gpr_we_;
        logic [2:0]  exp_code;
        logic [31:0] out;
    } mem_reg_t;

    function automatic mem_reg_t mem_reg_empty();
        mem_reg_t r;
        r          = mem_reg_t'(75'd0);
        r.ctrl_op  = CTRL_OP_NOP;
        r.gpr_we_  = 1'b1;
        r.exp_code = EXP_NO;
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] rd_buf_q, rd_buf_d;
    mem_reg_t    mem_q, mem_d;

    logic        is_mem_op_s, miss_align_s;
    logic [31:0] result_s;
    logic        busy_s, bus_req_s, bus_as_s, bus_rw_s;
    logic [29:0] bus_addr_s;
    logic [31:0] bus_wr_data_s;

    assign is_mem_op_s  = ex_en & ((ex_mem_op == MEM_OP_LDW) | (ex_mem_op == MEM_OP_STW));
    assign miss_align_s = is_mem_op_s & (ex_out[1:0] != 2'b00);

    // Bus FSM: next state, bus strobes, busy and the stage result; reset/flush park the bus.
    always_comb begin
        state_d       = state_q;
        rd_buf_d      = rd_buf_q;
        result_s      = ex_out;
        busy_s        = 1'b0;
        bus_req_s     = 1'b1;
        bus_as_s      = 1'b1;
        bus_rw_s      = 1'b1;
        bus_addr_s    = 30'd0;
        bus_wr_data_s = 32'd0;
        if (!reset || flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mem_op_s && !miss_align_s) begin
                        bus_req_s = 1'b0;
                        busy_s    = 1'b1;
                        state_d   = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    bus_req_s = 1'b0;
                    busy_s    = 1'b1;
                    if (!bus.bus_grnt_) begin
                        bus_as_s      = 1'b0;
                        bus_addr_s    = ex_out[31:2];
                        bus_rw_s      = (ex_mem_op == MEM_OP_LDW);
                        bus_wr_data_s = ex_mem_wr_data;
                        state_d       = ST_ACCESS;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_ACCESS: begin
                    if (!bus.bus_rdy_) begin
                        rd_buf_d = bus.bus_rd_data;
                        result_s = (ex_mem_op == MEM_OP_LDW) ? bus.bus_rd_data : ex_out;
                        state_d  = stall ? ST_WAIT : ST_IDLE;
                    end else begin
                        bus_req_s = 1'b0;
                        busy_s    = 1'b1;
                    end
                end
                ST_WAIT: begin
                    // Pipeline is frozen by stall; keep forwarding the captured load data.
                    result_s = (ex_mem_op == MEM_OP_LDW) ? rd_buf_q : ex_out;
                    state_d  = stall ? ST_WAIT : ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // MEM/WB register next value: flush beats stall (external or bus busy) beats load.
    always_comb begin
        mem_d = mem_q;
        if (flush) begin
            mem_d = mem_reg_empty();
        end else if (stall || busy_s) begin
            mem_d = mem_q;
        end else begin
            mem_d.pc       = ex_pc;
            mem_d.en       = ex_en;
            mem_d.br_flag  = ex_br_flag;
            mem_d.dst_addr = ex_dst_addr;
            mem_d.out      = result_s;
            if (miss_align_s) begin
                mem_d.ctrl_op  = CTRL_OP_NOP;
                mem_d.gpr_we_  = 1'b1;
                mem_d.exp_code = EXP_MISS_ALIGN;
            end else begin
                mem_d.ctrl_op  = ex_ctrl_op;
                mem_d.gpr_we_  = ex_gpr_we_;
                mem_d.exp_code = ex_exp_code;
            end
        end
    end

    // State, read buffer and MEM/WB register flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rd_buf_q <= 32'd0;
            mem_q    <= mem_reg_empty();
        end else begin
            state_q  <= state_d;
            rd_buf_q <= rd_buf_d;
            mem_q    <= mem_d;
        end
    end

    assign busy            = busy_s;
    assign fwd_data        = result_s;
    assign bus.bus_req_    = bus_req_s;
    assign bus.bus_as_     = bus_as_s;
    assign bus.bus_rw      = bus_rw_s;
    assign bus.bus_addr    = bus_addr_s;
    assign bus.bus_wr_data = bus_wr_data_s;

    assign mem_pc       = mem_q.pc;
    assign mem_en       = mem_q.en;
    assign mem_br_flag  = mem_q.br_flag;
    assign mem_ctrl_op  = mem_q.ctrl_op;
    assign mem_dst_addr = mem_q.dst_addr;
    assign mem_gpr_we_  = mem_q.gpr_we_;
    assign mem_exp_code = mem_q.exp_code;
    assign mem_out      = mem_q.out;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a transaction-level model of the stage.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, busy;
    logic [31:0] fwd_data;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [1:0]  ex_mem_op, ex_ctrl_op;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [4:0]  ex_dst_addr;
    logic [2:0]  ex_exp_code;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out;

    mem_stage_if bus();

    mem_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy), .fwd_data(fwd_data),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
        .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out), .bus(bus),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    localparam logic [1:0]  LDW = 2'b01;
    localparam logic [1:0]  STW = 2'b10;
    localparam logic [1:0]  NOP = 2'b00;
    localparam logic [74:0] MEM_EMPTY = {30'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b1, 3'd0, 32'd0};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: where the current transaction stands, plus the expected MEM/WB contents.
    bit          m_req, m_xfer, m_hold, m_adv;
    logic [31:0] m_buf;
    logic [74:0] m_mem;

    always @(negedge clk) begin : model_chk
        logic [64:0] e_bus;
        logic        e_busy, miss, aligned, n_req, n_xfer, n_hold;
        logic [31:0] e_res;
        e_bus   = {1'b1, 1'b1, 1'b1, 30'd0, 32'd0};
        e_busy  = 1'b0;
        e_res   = ex_out;
        miss    = ex_en && (ex_mem_op == LDW || ex_mem_op == STW) && (ex_out[1:0] != 2'b00);
        aligned = ex_en && (ex_mem_op == LDW || ex_mem_op == STW) && !miss;
        n_req   = 1'b0;
        n_xfer  = 1'b0;
        n_hold  = 1'b0;
        if (!reset) begin
            m_req = 1'b0; m_xfer = 1'b0; m_hold = 1'b0; m_buf = 32'd0; m_mem = MEM_EMPTY;
        end else if (flush) begin
            e_res = ex_out;
        end else if (m_hold) begin
            if (ex_mem_op == LDW) e_res = m_buf;
            n_hold = stall;
        end else if (m_xfer) begin
            if (!bus.bus_rdy_) begin
                m_buf = bus.bus_rd_data;
                if (ex_mem_op == LDW) e_res = bus.bus_rd_data;
                n_hold = stall;
            end else begin
                e_bus[64] = 1'b0; e_busy = 1'b1; n_xfer = 1'b1;
            end
        end else if (m_req) begin
            e_bus[64] = 1'b0; e_busy = 1'b1;
            if (!bus.bus_grnt_) begin
                e_bus  = {1'b0, 1'b0, (ex_mem_op == LDW), ex_out[31:2], ex_mem_wr_data};
                n_xfer = 1'b1;
            end else begin
                n_req = 1'b1;
            end
        end else if (aligned) begin
            e_bus[64] = 1'b0; e_busy = 1'b1; n_req = 1'b1;
        end
        chk("busy", 80'(busy), 80'(e_busy));
        chk("bus", 80'({bus.bus_req_, bus.bus_as_, bus.bus_rw, bus.bus_addr, bus.bus_wr_data}), 80'(e_bus));
        chk("fwd_data", 80'(fwd_data), 80'(e_res));
        chk("mem_regs", 80'({mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_,
                             mem_exp_code, mem_out}), 80'(m_mem));
        if (reset) begin
            if (flush) m_mem = MEM_EMPTY;
            else if (!(stall || e_busy))
                m_mem = miss ? {ex_pc, ex_en, ex_br_flag, 2'b00, ex_dst_addr, 1'b1, 3'd4, e_res}
                             : {ex_pc, ex_en, ex_br_flag, ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, e_res};
            m_adv  = flush || !(stall || e_busy);
            m_req  = n_req;
            m_xfer = n_xfer;
            m_hold = n_hold;
        end else begin
            m_adv = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic en, input logic [1:0] op, input logic [31:0] o, input logic [31:0] wd);
        ex_en = en; ex_mem_op = op; ex_out = o; ex_mem_wr_data = wd;
        ex_pc = 30'h0000_0abc; ex_br_flag = 1'b0; ex_ctrl_op = 2'b01; ex_dst_addr = 5'd7;
        ex_gpr_we_ = 1'b0; ex_exp_code = 3'd0;
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        set_ex(1'b0, NOP, 32'd0, 32'd0);
        bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b1; bus.bus_rd_data = 32'd0;
        @(negedge clk);
        chk("rst_busy", 80'(busy), 80'(1'b0));
        chk("rst_req", 80'(bus.bus_req_), 80'(1'b1));
        chk("rst_mem_en", 80'(mem_en), 80'(1'b0));
        chk("rst_gpr_we", 80'(mem_gpr_we_), 80'(1'b1));
        step(); reset = 1'b1; set_ex(1'b1, NOP, 32'h1234_5678, 32'd0);
        @(negedge clk);
        chk("alu_no_req", 80'(bus.bus_req_), 80'(1'b1));
        chk("alu_fwd", 80'(fwd_data), 80'(32'h1234_5678));
        step(); set_ex(1'b1, LDW, 32'h0000_0100, 32'd0); bus.bus_rd_data = 32'hdead_beef;
        @(negedge clk);
        chk("alu_mem_out", 80'(mem_out), 80'(32'h1234_5678));
        chk("alu_mem_en", 80'(mem_en), 80'(1'b1));
        chk("ld_req", 80'({bus.bus_req_, busy}), 80'(2'b01));
        step();
        @(negedge clk);
        chk("ld_wait_grant", 80'({bus.bus_req_, bus.bus_as_}), 80'(2'b01));
        step(); bus.bus_grnt_ = 1'b0;
        @(negedge clk);
        chk("ld_as", 80'(bus.bus_as_), 80'(1'b0));
        chk("ld_addr", 80'(bus.bus_addr), 80'(30'h40));
        chk("ld_rw", 80'(bus.bus_rw), 80'(1'b1));
        step(); bus.bus_grnt_ = 1'b1;
        @(negedge clk);
        chk("ld_as_once", 80'({bus.bus_as_, busy}), 80'(2'b11));
        chk("ld_hold_mem", 80'(mem_out), 80'(32'h1234_5678));
        step(); step(); bus.bus_rdy_ = 1'b0;
        @(negedge clk);
        chk("ld_rdy_busy", 80'(busy), 80'(1'b0));
        chk("ld_fwd", 80'(fwd_data), 80'(32'hdead_beef));
        step(); bus.bus_rdy_ = 1'b1; set_ex(1'b1, STW, 32'h0000_0010, 32'ha5a5_a5a5); bus.bus_rd_data = 32'hffff_ffff;
        @(negedge clk);
        chk("ld_mem_out", 80'(mem_out), 80'(32'hdead_beef));
        chk("st_req", 80'(bus.bus_req_), 80'(1'b0));
        step(); bus.bus_grnt_ = 1'b0;
        @(negedge clk);
        chk("st_rw", 80'(bus.bus_rw), 80'(1'b0));
        chk("st_addr", 80'(bus.bus_addr), 80'(30'h4));
        chk("st_wr_data", 80'(bus.bus_wr_data), 80'(32'ha5a5_a5a5));
        step(); bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b0;
        @(negedge clk);
        chk("st_fwd", 80'({busy, fwd_data}), 80'({1'b0, 32'h0000_0010}));
        step(); bus.bus_rdy_ = 1'b1; set_ex(1'b1, LDW, 32'h0000_0102, 32'd0);
        @(negedge clk);
        chk("st_mem_out", 80'(mem_out), 80'(32'h0000_0010));
        chk("mis_no_req", 80'({bus.bus_req_, busy}), 80'(2'b10));
        step(); set_ex(1'b1, LDW, 32'h0000_0200, 32'd0); bus.bus_rd_data = 32'hcafe_f00d;
        @(negedge clk);
        chk("mis_exp", 80'({mem_exp_code, mem_gpr_we_, mem_ctrl_op}), 80'({3'd4, 1'b1, 2'b00}));
        chk("mis_out", 80'(mem_out), 80'(32'h0000_0102));
        step(); bus.bus_grnt_ = 1'b0;
        step(); bus.bus_grnt_ = 1'b1; bus.bus_rdy_ = 1'b0; stall = 1'b1;
        @(negedge clk);
        chk("wt_fwd_rdy", 80'(fwd_data), 80'(32'hcafe_f00d));
        step(); bus.bus_rdy_ = 1'b1; bus.bus_rd_data = 32'h1111_1111;
        @(negedge clk);
        chk("wt_fwd_buf", 80'(fwd_data), 80'(32'hcafe_f00d));
        chk("wt_no_req", 80'({bus.bus_req_, busy}), 80'(2'b10));
        chk("wt_hold", 80'(mem_out), 80'(32'h0000_0102));
        step();
        @(negedge clk);
        chk("wt_no_req2", 80'({bus.bus_req_, busy}), 80'(2'b10));
        step(); stall = 1'b0;
        @(negedge clk);
        chk("wt_fwd_rel", 80'(fwd_data), 80'(32'hcafe_f00d));
        step(); set_ex(1'b1, LDW, 32'h0000_0300, 32'd0);
        @(negedge clk);
        chk("wt_mem_out", 80'(mem_out), 80'(32'hcafe_f00d));
        chk("rs_req", 80'(bus.bus_req_), 80'(1'b0));
        step(); bus.bus_grnt_ = 1'b0;
        step(); bus.bus_grnt_ = 1'b1; reset = 1'b0;
        @(negedge clk);
        chk("rs_release", 80'({bus.bus_req_, busy, mem_en}), 80'(3'b100));
        step(); reset = 1'b1;
        @(negedge clk);
        chk("rs_restart", 80'(bus.bus_req_), 80'(1'b0));
        step(); flush = 1'b1;
        @(negedge clk);
        chk("fl_release", 80'({bus.bus_req_, busy}), 80'(2'b10));
        step(); flush = 1'b0; set_ex(1'b0, NOP, 32'd0, 32'd0);
        @(negedge clk);
        chk("fl_idle", 80'({bus.bus_req_, mem_en}), 80'(2'b10));

        for (int i = 0; i < 4000; i++) begin
            step();
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            flush = ($urandom_range(0, 19) == 0);
            stall = ($urandom_range(0, 3) == 0);
            bus.bus_grnt_   = ($urandom_range(0, 4) < 2) ? 1'b0 : 1'b1;
            bus.bus_rdy_    = ($urandom_range(0, 4) < 2) ? 1'b0 : 1'b1;
            bus.bus_rd_data = $urandom;
            if (m_adv) begin
                ex_en          = ($urandom_range(0, 7) != 0);
                ex_mem_op      = 2'($urandom_range(0, 2));
                ex_out         = $urandom;
                if ($urandom_range(0, 3) != 0) ex_out[1:0] = 2'b00;
                ex_mem_wr_data = $urandom;
                ex_pc          = 30'($urandom);
                ex_br_flag     = 1'($urandom);
                ex_ctrl_op     = 2'($urandom);
                ex_dst_addr    = 5'($urandom);
                ex_gpr_we_     = 1'($urandom);
                ex_exp_code    = 3'($urandom);
            end
        end
        step();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
